// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencing fetch/decode/execute/memory/writeback for an RV32I subset datapath
module multicycle_control #(
  parameter int ALUOP_W = 3,
  parameter int MAX_WAIT = 15,
  parameter bit EXT_BRANCH = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               mem_ready,
  input  logic               alu_zero,
  input  logic               alu_lt,
  input  logic               alu_ltu,
  output logic               instr_req,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_src,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               write_src,
  output logic               alu_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal,
  output logic               timeout,
  output logic [2:0]         state
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  state_t st;
  logic [CW-1:0] cnt;
  logic [6:0] op_q;
  logic [2:0] f3_q;
  logic mem_phase, wait_out, legal, ld, sto, br, rt, taken;
  assign mem_phase = st == FETCH || st == MEM;
  // this low cycle is the MAX_WAIT-th consecutive one; a same-cycle ready still wins
  assign wait_out = !mem_ready && cnt == CW'(MAX_WAIT - 1);
  assign legal = opcode == OP_LD || opcode == OP_ST || opcode == OP_R || opcode == OP_I ||
                 (opcode == OP_BR && (funct3[2:1] == 2'b00 || (EXT_BRANCH && funct3[2])));
  assign ld  = op_q == OP_LD;
  assign sto = op_q == OP_ST;
  assign br  = op_q == OP_BR;
  assign rt  = op_q == OP_R;
  assign taken = (f3_q[2] ? (f3_q[1] ? alu_ltu : alu_lt) : alu_zero) ^ f3_q[0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      op_q <= '0;
      f3_q <= '0;
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else begin
      cnt <= (mem_phase && !mem_ready) ? cnt + CW'(1) : '0;
      case (st)
        IDLE: st <= FETCH;
        FETCH: begin
          if (mem_ready) st <= DECODE;
          else if (wait_out) begin
            st <= TRAP;
            timeout <= 1'b1;
          end
        end
        DECODE: begin
          op_q <= opcode;
          f3_q <= funct3;
          if (legal) st <= EXEC;
          else begin
            st <= TRAP;
            illegal <= 1'b1;
          end
        end
        EXEC: st <= (ld || sto) ? MEM : br ? FETCH : WB;
        MEM: begin
          if (mem_ready) st <= ld ? WB : FETCH;
          else if (wait_out) begin
            st <= TRAP;
            timeout <= 1'b1;
          end
        end
        WB: st <= FETCH;
        default: st <= TRAP;
      endcase
    end
  end
  assign state     = st;
  assign instr_req = st == FETCH;
  assign ir_write  = st == FETCH && mem_ready;
  assign pc_src    = st == EXEC && br && taken;
  assign pc_write  = ir_write || pc_src;
  assign mem_read  = st == MEM && ld;
  assign mem_write = st == MEM && sto;
  assign reg_write = st == WB;
  assign write_src = st == WB && ld;
  assign alu_src   = (st == EXEC && !br && !rt) || st == MEM;
  assign alu_op    = st != EXEC ? '0 : br ? ALUOP_W'(1) : rt ? ALUOP_W'(2) : (ld || sto) ? '0 : ALUOP_W'(3);
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed transaction-level checks of the multicycle control FSM
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic mem_ready = 1'b0, alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0;
  int sel = 0;
  logic [16:0] o [3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    logic instr_req, ir_write, pc_write, pc_src, mem_read, mem_write, reg_write, write_src, alu_src;
    logic illegal, timeout;
    logic [2:0] alu_op, state;
    multicycle_control #(.ALUOP_W(3), .MAX_WAIT(g == 2 ? 4 : 15), .EXT_BRANCH(g != 1)) dut (
      .clk(clk), .rst_n(rst_n && sel == g), .opcode(opcode), .funct3(funct3),
      .mem_ready(mem_ready), .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
      .instr_req(instr_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .write_src(write_src),
      .alu_src(alu_src), .alu_op(alu_op), .illegal(illegal), .timeout(timeout), .state(state));
    assign o[g] = {instr_req, ir_write, pc_write, pc_src, mem_read, mem_write, reg_write,
                   write_src, alu_src, alu_op, illegal, timeout, state};
  end
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011, BR = 7'b1100011;
  int n_chk = 0, n_fail = 0, ncyc = 0, mw = 15;
  bit ext = 1'b1, trapped = 1'b0, exp_v = 1'b0;
  logic m_ill = 1'b0, m_to = 1'b0;
  logic [16:0] exp_o = '0;
  string tag = "";
  always @(negedge clk) if (exp_v) begin
    n_chk++;
    if (o[sel] !== exp_o) begin
      n_fail++;
      $display("FAIL %s (dut %0d, t=%0t): got %h expected %h", tag, sel, $time, o[sel], exp_o);
    end
  end
  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask
  function automatic logic [16:0] cv(input logic [2:0] st, input logic req, irw, pcw, pcs, mr, mwr, rw, ws, as,
                                     input logic [2:0] aop);
    return {req, irw, pcw, pcs, mr, mwr, rw, ws, as, aop, m_ill, m_to, st};
  endfunction
  function automatic bit is_legal(input logic [6:0] op, input logic [2:0] f3);
    if (op == LD || op == ST || op == RT || op == IT) return 1'b1;
    if (op == BR) return f3 == 3'd0 || f3 == 3'd1 || (ext && f3 >= 3'd4);
    return 1'b0;
  endfunction
  function automatic logic br_taken(input logic [2:0] f3, input logic z, lt, ltu);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      default: return !ltu;
    endcase
  endfunction
  task automatic cyc(input logic rdy, input logic [6:0] op, input logic [2:0] f3, input logic [16:0] e, input string t);
    @(posedge clk);
    #1;
    mem_ready = rdy;
    opcode = op;
    funct3 = f3;
    exp_o = e;
    tag = t;
    exp_v = 1'b1;
    ncyc++;
    @(negedge clk);
    #1;
  endtask
  task automatic do_reset(input int s);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sel = s;
    mw = s == 2 ? 4 : 15;
    ext = s != 1;
    m_ill = 1'b0;
    m_to = 1'b0;
    exp_o = '0;
    tag = "reset";
    exp_v = 1'b1;
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ready = 1'b0;
    tag = "idle";
    @(negedge clk);
    #1;
  endtask
  // Expected trace of one instruction, generated from its class and the memory wait pattern
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int wf, input int wm,
                           input logic z, lt, ltu, input int stop_mem);
    logic [6:0] jo;
    logic [2:0] jf;
    logic tk, ld, sto, as;
    logic [2:0] aop;
    jo = op ^ 7'h7f;
    jf = f3 ^ 3'b111;
    ld = op == LD;
    sto = op == ST;
    ncyc = 0;
    trapped = 1'b0;
    alu_zero = z;
    alu_lt = lt;
    alu_ltu = ltu;
    for (int k = 1; k <= wf; k++) begin
      cyc(1'b0, jo, jf, cv(3'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0), "fetch_wait");
      if (k == mw) begin
        m_to = 1'b1;
        cyc(1'b0, jo, jf, cv(3'd6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0), "trap_fetch_timeout");
        trapped = 1'b1;
        return;
      end
    end
    cyc(1'b1, jo, jf, cv(3'd1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 3'd0), "fetch");
    cyc(1'b0, op, f3, cv(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0), "decode");
    if (!is_legal(op, f3)) begin
      m_ill = 1'b1;
      cyc(1'b0, jo, jf, cv(3'd6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0), "trap_illegal");
      trapped = 1'b1;
      return;
    end
    if (op == BR) begin
      tk = br_taken(f3, z, lt, ltu);
      cyc(1'b0, jo, jf, cv(3'd3, 0, 0, tk, tk, 0, 0, 0, 0, 0, 3'd1), "exec_branch");
      return;
    end
    aop = op == RT ? 3'd2 : op == IT ? 3'd3 : 3'd0;
    as = op != RT;
    cyc(1'b0, jo, jf, cv(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, as, aop), "exec");
    if (ld || sto) begin
      for (int k = 1; k <= wm; k++) begin
        cyc(1'b0, jo, jf, cv(3'd4, 0, 0, 0, 0, ld, sto, 0, 0, 1, 3'd0), "mem_wait");
        if (k == stop_mem) return;
        if (k == mw) begin
          m_to = 1'b1;
          cyc(1'b0, jo, jf, cv(3'd6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0), "trap_mem_timeout");
          trapped = 1'b1;
          return;
        end
      end
      cyc(1'b1, jo, jf, cv(3'd4, 0, 0, 0, 0, ld, sto, 0, 0, 1, 3'd0), "mem");
      if (sto) return;
    end
    cyc(1'b0, jo, jf, cv(3'd5, 0, 0, 0, 0, 0, 0, 1, ld, 0, 3'd0), "wb");
  endtask
  task automatic trap_hold(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'($urandom), 7'($urandom), 3'($urandom), cv(3'd6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0), "trap_hold");
  endtask
  initial begin
    do_reset(0);
    run_instr(RT, 3'd0, 0, 0, 0, 0, 0, 0);  chk("lat_r", ncyc, 4);
    run_instr(IT, 3'd2, 2, 0, 0, 0, 0, 0);  chk("lat_i_wait2", ncyc, 6);
    run_instr(LD, 3'd2, 0, 3, 0, 0, 0, 0);  chk("lat_load_wait3", ncyc, 8);
    run_instr(ST, 3'd2, 0, 0, 0, 0, 0, 0);  chk("lat_store", ncyc, 4);
    run_instr(LD, 3'd2, 0, 0, 0, 0, 0, 0);  chk("lat_load", ncyc, 5);
    run_instr(BR, 3'd0, 0, 0, 1, 0, 0, 0);  chk("lat_beq", ncyc, 3);
    chk("beq_taken_pcsrc", int'(o[0][13]), 1);
    run_instr(BR, 3'd0, 0, 0, 0, 1, 1, 0);
    run_instr(BR, 3'd1, 0, 0, 0, 0, 0, 0);
    run_instr(BR, 3'd4, 0, 0, 1, 0, 1, 0);
    run_instr(BR, 3'd5, 0, 0, 0, 1, 0, 0);
    chk("bge_lt_pcwrite", int'(o[0][14]), 0);
    run_instr(BR, 3'd6, 0, 0, 0, 0, 1, 0);
    run_instr(BR, 3'd7, 0, 0, 0, 1, 0, 0);
    chk("sane_no_trap", int'(trapped), 0);
    run_instr(ST, 3'd2, 0, 5, 0, 0, 0, 2);
    chk("store_mem_write_before_rst", int'(o[0][11]), 1);
    do_reset(0);
    run_instr(RT, 3'd0, 0, 0, 0, 0, 0, 0);  chk("lat_r_after_rst", ncyc, 4);
    run_instr(7'h7f, 3'd0, 0, 0, 0, 0, 0, 0);
    chk("illegal_trapped", int'(trapped), 1);
    chk("illegal_state", int'(o[0][2:0]), 6);
    chk("illegal_flag", int'(o[0][4]), 1);
    trap_hold(20);
    do_reset(0);
    run_instr(BR, 3'd2, 0, 0, 0, 0, 0, 0);  chk("br_f3_010_trap", int'(trapped), 1);
    do_reset(1);
    run_instr(BR, 3'd4, 0, 0, 0, 1, 0, 0);  chk("noext_blt_trap", int'(trapped), 1);
    trap_hold(3);
    do_reset(1);
    run_instr(BR, 3'd1, 0, 0, 0, 0, 0, 0);  chk("noext_bne_ok", int'(trapped), 0);
    do_reset(2);
    run_instr(RT, 3'd0, 4, 0, 0, 0, 0, 0);
    chk("fetch_timeout_trap", int'(trapped), 1);
    chk("fetch_timeout_flag", int'(o[2][3]), 1);
    chk("fetch_timeout_cycles", ncyc, 5);
    trap_hold(5);
    do_reset(2);
    run_instr(RT, 3'd0, 3, 0, 0, 0, 0, 0);
    chk("ready_last_wait_no_trap", int'(trapped), 0);
    chk("lat_r_wait3", ncyc, 7);
    run_instr(LD, 3'd2, 0, 4, 0, 0, 0, 0);  chk("mem_timeout_trap", int'(trapped), 1);
    trap_hold(3);
    do_reset(2);
    run_instr(LD, 3'd2, 0, 3, 0, 0, 0, 0);  chk("mem_wait3_ok", ncyc, 8);
    do_reset(0);
    exp_v = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control unit for the RV32I datapath subset: load, store, R-type, I-type ALU and conditional branches. It replaces single-cycle opcode decoding with a state machine that sequences fetch, decode, execute, memory and writeback. Memory accesses use a ready handshake with a bounded wait. Illegal encodings and memory timeouts park the core in a trap state. It sits between the instruction register and the shared-memory datapath, driving every datapath enable and mux select.

## Interface
- ALUOP_W, 3, width of alu_op; encodings 000 add (address), 001 branch compare, 010 R-type, 011 I-type; upper bits zero.
- MAX_WAIT, 15, maximum consecutive cycles with mem_ready low in FETCH or MEM before a timeout trap; must be ≥1.
- EXT_BRANCH, 1, when 1 adds BLT/BGE/BLTU/BGEU; when 0 only BEQ/BNE are legal.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  7  instruction bits [6:0] from the instruction register
- funct3  in  3  instruction bits [14:12]
- mem_ready  in  1  memory completes the current instr/data request this cycle
- alu_zero  in  1  ALU result equals zero
- alu_lt  in  1  signed rs1<rs2
- alu_ltu  in  1  unsigned rs1<rs2
- instr_req  out  1  instruction fetch request
- ir_write  out  1  load instruction register
- pc_write  out  1  update PC
- pc_src  out  1  0 = PC+4, 1 = branch target
- mem_read  out  1  data load request
- mem_write  out  1  data store request
- reg_write  out  1  register-file write enable
- write_src  out  1  0 = ALU result, 1 = memory data
- alu_src  out  1  0 = rs2, 1 = immediate
- alu_op  out  ALUOP_W  ALU operation class
- illegal  out  1  sticky: illegal instruction trapped
- timeout  out  1  sticky: memory wait exceeded
- state  out  3  current state, for debug

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- IDLE: all control outputs are 0. Next state is FETCH.
- FETCH:
  - instr_req=1.
  - If mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Latch opcode and funct3 into internal registers. All later states use only the latched copies.
  - Legal opcodes: 0000011 load, 0100011 store, 0110011 R, 0010011 I, 1100011 branch.
  - Legal branch funct3: 000 BEQ and 001 BNE. With EXT_BRANCH=1, also 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - Anything else goes to TRAP with illegal set. Otherwise go to EXEC.
- EXEC:
  - Load/store: alu_op=000, alu_src=1, then go to MEM.
  - R-type: alu_op=010, alu_src=0, then go to WB.
  - I-type: alu_op=011, alu_src=1, then go to WB.
  - Branch: alu_op=001, alu_src=0. The taken condition is:
    - BEQ: alu_zero
    - BNE: !alu_zero
    - BLT: alu_lt
    - BGE: !alu_lt
    - BLTU: alu_ltu
    - BGEU: !alu_ltu
  - Branch taken: pc_write=1, pc_src=1. Not taken: pc_write=0. Either way, go to FETCH.
- MEM:
  - alu_op=000, alu_src=1.
  - mem_read=1 for a load, mem_write=1 for a store, held constant until mem_ready.
  - On mem_ready: a load goes to WB, a store goes to FETCH.
- WB: reg_write=1 for exactly one cycle. write_src=1 for a load, 0 otherwise. Next state is FETCH.
- TRAP: all control outputs are 0 and the FSM stays in TRAP until reset. illegal and timeout stay sticky.
- Wait counter:
  - Width is clog2(MAX_WAIT+1).
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle in FETCH or MEM with mem_ready=0.
  - When the count reaches MAX_WAIT with mem_ready still 0, the next state is TRAP with timeout=1.
  - If mem_ready=1 arrives in the same cycle the count reaches MAX_WAIT, the handshake wins and no trap occurs.
- Control outputs not listed for a state are 0.

## Timing
- Reset:
  - Asserting rst_n low forces state=IDLE, clears illegal, timeout, the wait counter and the latched instruction fields.
  - Every output is 0 while rst_n is low, including mid-instruction; any pending memory request is dropped.
- Output decode:
  - Outputs decode combinationally from the state and latched fields.
  - ir_write, pc_write in FETCH and the MEM exit depend combinationally on mem_ready in the same cycle.
  - pc_write/pc_src in EXEC depend combinationally on alu_zero, alu_lt and alu_ltu.
- Latency with zero-wait memory (mem_ready high on the first request cycle), IDLE excluded:
  - Branch: 3 cycles
  - R/I: 4 cycles
  - Store: 4 cycles
  - Load: 5 cycles
  - Each wait cycle adds 1.
- Handshake: instr_req/mem_read/mem_write rise on state entry and fall the cycle after mem_ready is sampled high. The request never drops before mem_ready.
- illegal/timeout assert on the first cycle in TRAP.

## Test plan
- Zero-wait R-type 0110011 after reset: states 1→2→3→5→1; alu_op=010 in EXEC; reg_write=1 only in WB; alu_src=0, write_src=0.
- Load 0000011 with mem_ready low for 3 cycles in MEM: mem_read=1 for 4 cycles; WB has reg_write=1, write_src=1; total 8 cycles.
- Branches with funct3=000: alu_zero=1 gives pc_write=1, pc_src=1 in EXEC. With funct3=101 (BGE), alu_lt=1 gives pc_write=0. EXT_BRANCH=0 with funct3=100 traps, illegal=1.
- Opcode 1111111: TRAP on the cycle after DECODE; illegal=1; all outputs 0 for 20 further cycles; rst_n low clears to IDLE.
- MAX_WAIT=4, mem_ready held 0 in FETCH: after 4 wait cycles go to TRAP with timeout=1. The same run with mem_ready=1 on the 4th wait cycle proceeds to DECODE with no trap.
- rst_n asserted mid-MEM during a store: mem_write drops immediately; after release, IDLE then FETCH with instr_req=1.
